// File: rtl/recibiendo_pin_param_pkg.sv
// Shared definitions for the PIN receiver: FSM state encoding and the
// special keypad codes that are not decimal digits.
package pin_pkg;

    localparam logic [1:0] ENC_IDLE      = 2'd0;
    localparam logic [1:0] ENC_CAPTURA   = 2'd1;
    localparam logic [1:0] ENC_COMPARA   = 2'd2;
    localparam logic [1:0] ENC_BLOQUEADO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = ENC_IDLE,
        ST_CAPTURA   = ENC_CAPTURA,
        ST_COMPARA   = ENC_COMPARA,
        ST_BLOQUEADO = ENC_BLOQUEADO
    } estado_t;

    localparam logic [3:0] DIG_BORRAR   = 4'hA;
    localparam logic [3:0] DIG_CANCELAR = 4'hB;

    function automatic logic es_digito(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/recibiendo_pin_param_if.sv
// Keypad / session bus between the cashier control logic and the PIN receiver.
//   master: card-reader side, drives habilitar, digit strobes and the stored PIN
//   slave : PIN receiver, drives result pulses, warning/lock levels and attempt count
interface recibiendo_pin_param_if #(
    parameter int N_DIGITOS    = 4,
    parameter int MAX_INTENTOS = 3
);
    logic                                  habilitar;
    logic                                  digito_stb;
    logic [3:0]                            digito;
    logic [4*N_DIGITOS-1:0]                pin_correcto;
    logic                                  pin_incorrecto;
    logic                                  advertencia;
    logic                                  bloqueo;
    logic                                  fin;
    logic                                  timeout;
    logic [$clog2(MAX_INTENTOS+1)-1:0]     intentos;

    modport master (
        output habilitar, digito_stb, digito, pin_correcto,
        input  pin_incorrecto, advertencia, bloqueo, fin, timeout, intentos
    );

    modport slave (
        input  habilitar, digito_stb, digito, pin_correcto,
        output pin_incorrecto, advertencia, bloqueo, fin, timeout, intentos
    );
endinterface

// File: rtl/recibiendo_pin_param_contador_timeout.sv
// Inter-digit timer. Down-counter reloaded by clr_i; while en_i is high it
// counts down and tc_o fires on the cycle that would reach zero, i.e. after
// TIMEOUT_CICLOS enabled cycles since the last reload.
//   clk, reset : system clock, async active-low reset
//   clr_i      : reload (has priority, also masks tc_o)
//   en_i       : count enable
//   tc_o       : terminal-count pulse
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [W-1:0] CARGA = W'(TIMEOUT_CICLOS);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CARGA;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CARGA;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && !clr_i && (cnt_q == W'(1));

endmodule

// File: rtl/recibiendo_pin_param.sv
// PIN receiver: collects N_DIGITOS BCD digits per attempt, compares them with
// the stored PIN, counts failures, warns on the last attempt and locks after
// MAX_INTENTOS failures. Supports backspace, cancel and inter-digit timeout.
//   clk, reset : system clock, async active-low reset
//   bus        : slave side of recibiendo_pin_param_if (inputs from card reader,
//                registered result outputs)
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no session; waits for habilitar
// ST_CAPTURA   | collecting digits; handles borrar/cancelar/timeout
// ST_COMPARA   | one cycle: compare buffer with stored PIN, update attempts
// ST_BLOQUEADO | locked out; only reset leaves
module recibiendo_pin_param
    import pin_pkg::*;
#(
    parameter int N_DIGITOS      = 4,
    parameter int MAX_INTENTOS   = 3,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input logic                  clk,
    input logic                  reset,
    recibiendo_pin_param_if.slave bus
);
    localparam int BW = 4 * N_DIGITOS;
    localparam int CW = $clog2(N_DIGITOS + 1);
    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam logic [CW-1:0] N_CNT    = CW'(N_DIGITOS);
    localparam logic [IW-1:0] INT_MAX  = IW'(MAX_INTENTOS);
    localparam logic [IW-1:0] INT_AVISO = IW'(MAX_INTENTOS - 1);

    estado_t         estado_q, estado_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   int_q, int_d;
    logic [IW-1:0]   int_inc;
    logic            fin_q, fin_d;
    logic            mal_q, mal_d;
    logic            tmo_q, tmo_d;
    logic            adv_q, adv_d;
    logic            bloq_q, bloq_d;

    logic            stb_valido;
    logic            tmr_clr, tmr_en, tmr_tc;

    // Codes C-F are not "valid" strobes: they must not restart the timer.
    assign stb_valido = bus.digito_stb && (bus.digito <= DIG_CANCELAR);
    assign tmr_clr    = (estado_q != ST_CAPTURA) || stb_valido;
    assign tmr_en     = (estado_q == ST_CAPTURA) && (cnt_q != '0);
    assign int_inc    = int_q + IW'(1);

    contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        estado_d = estado_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        int_d    = int_q;
        adv_d    = adv_q;
        bloq_d   = bloq_q;
        fin_d    = 1'b0;
        mal_d    = 1'b0;
        tmo_d    = 1'b0;

        case (estado_q)
            ST_IDLE: begin
                if (bus.habilitar) begin
                    estado_d = ST_CAPTURA;
                    buf_d    = '0;
                    cnt_d    = '0;
                end
            end

            ST_CAPTURA: begin
                if (!bus.habilitar) begin
                    estado_d = ST_IDLE;
                    buf_d    = '0;
                    cnt_d    = '0;
                end else if (cnt_q == N_CNT) begin
                    // entry complete: strobes in this cycle are dropped
                    estado_d = ST_COMPARA;
                end else if (stb_valido) begin
                    if (es_digito(bus.digito)) begin
                        buf_d = (buf_q << 4) | BW'(bus.digito);
                        cnt_d = cnt_q + CW'(1);
                    end else if (bus.digito == DIG_BORRAR) begin
                        if (cnt_q != '0) begin
                            buf_d = buf_q >> 4;
                            cnt_d = cnt_q - CW'(1);
                        end
                    end else begin
                        buf_d = '0;
                        cnt_d = '0;
                    end
                end else if (tmr_tc) begin
                    buf_d = '0;
                    cnt_d = '0;
                    tmo_d = 1'b1;
                end
            end

            ST_COMPARA: begin
                buf_d = '0;
                cnt_d = '0;
                if (buf_q == bus.pin_correcto) begin
                    fin_d    = 1'b1;
                    int_d    = '0;
                    adv_d    = 1'b0;
                    estado_d = ST_IDLE;
                end else begin
                    mal_d = 1'b1;
                    int_d = int_inc;
                    adv_d = (int_inc == INT_AVISO);
                    if (int_inc == INT_MAX) begin
                        bloq_d   = 1'b1;
                        adv_d    = 1'b0;
                        estado_d = ST_BLOQUEADO;
                    end else begin
                        estado_d = ST_CAPTURA;
                    end
                end
            end

            ST_BLOQUEADO: begin
                estado_d = ST_BLOQUEADO;
            end

            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= ST_IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            int_q    <= '0;
            adv_q    <= 1'b0;
            bloq_q   <= 1'b0;
            fin_q    <= 1'b0;
            mal_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            int_q    <= int_d;
            adv_q    <= adv_d;
            bloq_q   <= bloq_d;
            fin_q    <= fin_d;
            mal_q    <= mal_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.fin            = fin_q;
    assign bus.pin_incorrecto = mal_q;
    assign bus.timeout        = tmo_q;
    assign bus.advertencia    = adv_q;
    assign bus.bloqueo        = bloq_q;
    assign bus.intentos       = int_q;

endmodule

// File: tb/tb_recibiendo_pin_param.sv
module tb_recibiendo_pin_param;
    localparam int N    = 4;
    localparam int MAXI = 3;
    localparam int TMO  = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    recibiendo_pin_param_if #(.N_DIGITOS(N), .MAX_INTENTOS(MAXI)) bus ();

    recibiendo_pin_param #(
        .N_DIGITOS(N), .MAX_INTENTOS(MAXI), .TIMEOUT_CICLOS(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_fin = 0, n_mal = 0, n_tmo = 0;

    // pulse counters: a pulse stuck high is counted once per cycle
    always @(posedge clk) begin
        #1;
        if (bus.fin === 1'b1)            n_fin++;
        if (bus.pin_incorrecto === 1'b1) n_mal++;
        if (bus.timeout === 1'b1)        n_tmo++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [3:0] d);
        @(negedge clk);
        bus.digito_stb = 1'b1;
        bus.digito     = d;
        @(negedge clk);
        bus.digito_stb = 1'b0;
        bus.digito     = 4'h0;
    endtask

    task automatic enter_seq(input logic [31:0] seq, input int len);
        for (int j = 0; j < len; j++) strobe(seq[4*(len-1-j) +: 4]);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        wait_n(2);
        reset = 1'b1;
        wait_n(1);
    endtask

    typedef struct {
        logic [31:0] seq;
        int          len;
        int          e_fin;
        int          e_mal;
        int          e_int;
        int          e_adv;
        int          e_bloq;
    } vec_t;

    vec_t tabla [10];

    // reference model state
    int          m_int;
    bit          m_lock;
    logic [3:0]  q [$];

    initial begin
        int f0, m0, t0, found, steps, r, nat;
        logic [3:0]  c;
        logic [15:0] v;
        bit          match;

        tabla[0] = '{32'h1234,    4, 1, 0, 0, 0, 0};
        tabla[1] = '{32'h19A234,  6, 1, 0, 0, 0, 0};
        tabla[2] = '{32'h12B1234, 7, 1, 0, 0, 0, 0};
        tabla[3] = '{32'hA1234,   5, 1, 0, 0, 0, 0};
        tabla[4] = '{32'h1235,    4, 0, 1, 1, 0, 0};
        tabla[5] = '{32'h1234,    4, 1, 0, 0, 0, 0};
        tabla[6] = '{32'h1235,    4, 0, 1, 1, 0, 0};
        tabla[7] = '{32'h12C35,   5, 0, 1, 2, 1, 0};
        tabla[8] = '{32'h1235,    4, 0, 1, 3, 0, 1};
        tabla[9] = '{32'h1234,    4, 0, 0, 3, 0, 1};

        bus.habilitar    = 1'b0;
        bus.digito_stb   = 1'b0;
        bus.digito       = 4'h0;
        bus.pin_correcto = 16'h1234;
        reset            = 1'b0;

        #13;
        check("rst_fin",   bus.fin, 0);
        check("rst_mal",   bus.pin_incorrecto, 0);
        check("rst_tmo",   bus.timeout, 0);
        check("rst_adv",   bus.advertencia, 0);
        check("rst_bloq",  bus.bloqueo, 0);
        check("rst_int",   bus.intentos, 0);
        wait_n(1);
        reset = 1'b1;
        bus.habilitar = 1'b1;
        wait_n(3);

        // table: correct entries, edits, failures up to lock
        for (int i = 0; i < 10; i++) begin
            f0 = n_fin;
            m0 = n_mal;
            enter_seq(tabla[i].seq, tabla[i].len);
            wait_n(6);
            check($sformatf("tab%0d_fin", i),  n_fin - f0, tabla[i].e_fin);
            check($sformatf("tab%0d_mal", i),  n_mal - m0, tabla[i].e_mal);
            check($sformatf("tab%0d_int", i),  bus.intentos, tabla[i].e_int);
            check($sformatf("tab%0d_adv", i),  bus.advertencia, tabla[i].e_adv);
            check($sformatf("tab%0d_bloq", i), bus.bloqueo, tabla[i].e_bloq);
        end

        // asynchronous reset while locked
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_bloq", bus.bloqueo, 0);
        check("arst_int",  bus.intentos, 0);
        wait_n(2);
        reset = 1'b1;
        wait_n(3);

        // exact latency of fin
        enter_seq(32'h123, 3);
        @(negedge clk);
        bus.digito_stb = 1'b1;
        bus.digito     = 4'h4;
        @(negedge clk);
        bus.digito_stb = 1'b0;
        check("lat_e0", bus.fin, 0);
        wait_n(1);
        check("lat_e1", bus.fin, 0);
        wait_n(1);
        check("lat_e2", bus.fin, 1);
        wait_n(1);
        check("lat_e3", bus.fin, 0);
        wait_n(3);

        // inter-digit timeout
        t0 = n_tmo;
        enter_seq(32'h12, 2);
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.timeout === 1'b1) begin
                found = k;
                break;
            end
        end
        check("tmo_seen", (found >= TMO - 1) && (found <= TMO + 1), 1);
        wait_n(3);
        check("tmo_pulse", n_tmo - t0, 1);
        check("tmo_int",   bus.intentos, 0);
        f0 = n_fin;
        enter_seq(32'h1234, 4);
        wait_n(6);
        check("tmo_after_fin", n_fin - f0, 1);
        t0 = n_tmo;
        wait_n(3 * TMO);
        check("tmo_empty", n_tmo - t0, 0);

        // habilitar drop mid-entry keeps attempts, clears the buffer
        enter_seq(32'h1235, 4);
        wait_n(6);
        check("hab_int1", bus.intentos, 1);
        f0 = n_fin; m0 = n_mal; t0 = n_tmo;
        enter_seq(32'h12, 2);
        bus.habilitar = 1'b0;
        wait_n(2 * TMO);
        check("hab_fin", n_fin - f0, 0);
        check("hab_mal", n_mal - m0, 0);
        check("hab_tmo", n_tmo - t0, 0);
        check("hab_int", bus.intentos, 1);
        bus.habilitar = 1'b1;
        wait_n(3);
        enter_seq(32'h1234, 4);
        wait_n(6);
        check("hab_refin", n_fin - f0, 1);
        check("hab_int0",  bus.intentos, 0);

        // reset mid-entry
        enter_seq(32'h1235, 4);
        wait_n(6);
        enter_seq(32'h12, 2);
        #3;
        reset = 1'b0;
        #1;
        check("mrst_int", bus.intentos, 0);
        wait_n(2);
        reset = 1'b1;
        wait_n(3);
        f0 = n_fin;
        enter_seq(32'h1234, 4);
        wait_n(6);
        check("mrst_fin", n_fin - f0, 1);

        // randomized sessions against the model
        m_int  = 0;
        m_lock = 0;
        for (int s = 0; s < 30; s++) begin
            if (m_lock) begin
                do_reset();
                m_int  = 0;
                m_lock = 0;
            end
            bus.habilitar = 1'b0;
            wait_n(2);
            for (int k = 0; k < N; k++) bus.pin_correcto[4*k +: 4] = 4'($urandom_range(0, 9));
            bus.habilitar = 1'b1;
            wait_n(3);
            nat = $urandom_range(1, 3);
            for (int a = 0; a < nat; a++) begin
                if (m_lock) break;
                q.delete();
                steps = 0;
                f0 = n_fin;
                m0 = n_mal;
                while (q.size() < N) begin
                    r = (steps > 30) ? 0 : $urandom_range(0, 99);
                    if (r < 75) begin
                        if ($urandom_range(0, 3) != 0)
                            c = bus.pin_correcto[4*(N-1-q.size()) +: 4];
                        else
                            c = 4'($urandom_range(0, 9));
                    end else if (r < 85) c = 4'hA;
                    else if (r < 90)     c = 4'hB;
                    else                 c = 4'($urandom_range(12, 15));
                    wait_n($urandom_range(0, 2));
                    strobe(c);
                    if (c <= 4'd9)       q.push_back(c);
                    else if (c == 4'hA)  begin if (q.size() > 0) void'(q.pop_back()); end
                    else if (c == 4'hB)  q.delete();
                    steps++;
                end
                v = '0;
                foreach (q[i]) v = {v[11:0], q[i]};
                match = (v == bus.pin_correcto);
                if (match) m_int = 0;
                else begin
                    m_int++;
                    if (m_int == MAXI) m_lock = 1;
                end
                wait_n(6);
                check($sformatf("rnd%0d_%0d_fin", s, a), n_fin - f0, match ? 1 : 0);
                check($sformatf("rnd%0d_%0d_mal", s, a), n_mal - m0, match ? 0 : 1);
                check($sformatf("rnd%0d_%0d_int", s, a), bus.intentos, m_int);
                check($sformatf("rnd%0d_%0d_adv", s, a), bus.advertencia,
                      (!m_lock && m_int == MAXI - 1) ? 1 : 0);
                check($sformatf("rnd%0d_%0d_bloq", s, a), bus.bloqueo, m_lock ? 1 : 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
